// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC sequencer: data width, op codes and state encoding.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package mac_seq_ctrl_pkg;

    localparam int DATA_WIDTH = `DATA_WIDTH;

    localparam logic OP_DOT   = 1'b0;
    localparam logic OP_CHAIN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a two-stage MAC: pops operand FIFOs, drives the MAC controls,
// waits out the pipeline latency and hands the result over a valid/ready port.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    input  logic                  a_empty,
    input  logic                  b_empty,
    output logic                  a_rd,
    output logic                  b_rd,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  mulsel,
    output logic                  addsel,
    output logic [DATA_WIDTH-1:0] data_0,
    output logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] mac_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data
);

    state_t                  state, state_nx;
    logic                    op_lat, op_nx;
    logic [LEN_W-1:0]        remain, remain_nx;
    logic [1:0]              drain_cnt, drain_nx;
    logic                    started, started_nx;
    logic                    add_p0, add_nx;
    logic [DATA_WIDTH-1:0]   d0_nx, d1_nx;
    logic                    mulsel_nx;
    logic                    res_valid_nx;
    logic [DATA_WIDTH-1:0]   res_data_nx;
    logic                    issue;
    logic [DATA_WIDTH-1:0]   bub_d0, bub_d1;
    logic                    bub_mul, bub_add;

    assign busy = (state != IDLE);

    // Bubble drive: DOT feeds a zero product into a held accumulator; CHAIN
    // multiplies the held product by 1. Before the first term the flush drive is used.
    always_comb begin
        bub_d0  = '0;
        bub_d1  = '0;
        bub_mul = 1'b0;
        bub_add = 1'b0;
        if (op_lat == OP_DOT) begin
            bub_add = started;
        end else if (started) begin
            bub_d0  = DATA_WIDTH'(1);
            bub_d1  = DATA_WIDTH'(1);
            bub_mul = 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        op_nx        = op_lat;
        remain_nx    = remain;
        drain_nx     = drain_cnt;
        started_nx   = started;
        d0_nx        = '0;
        d1_nx        = '0;
        mulsel_nx    = 1'b0;
        add_nx       = 1'b0;
        res_valid_nx = res_valid;
        res_data_nx  = res_data;
        issue        = 1'b0;
        a_rd         = 1'b0;
        b_rd         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    op_nx       = op;
                    remain_nx   = len;
                    started_nx  = 1'b0;
                    drain_nx    = 2'd0;
                    res_data_nx = '0;
                    state_nx    = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue = !a_empty && ((op_lat == OP_CHAIN) || !b_empty);
                a_rd  = issue;
                b_rd  = issue && (op_lat == OP_DOT);
                if (issue) begin
                    remain_nx  = remain - LEN_W'(1);
                    started_nx = 1'b1;
                    d0_nx      = a_data;
                    if (remain == LEN_W'(1)) state_nx = DRAIN;
                    if (op_lat == OP_DOT) begin
                        d1_nx  = b_data;
                        add_nx = started;
                    end else begin
                        d1_nx     = DATA_WIDTH'(1);
                        mulsel_nx = started;
                    end
                end else begin
                    d0_nx     = bub_d0;
                    d1_nx     = bub_d1;
                    mulsel_nx = bub_mul;
                    add_nx    = bub_add;
                end
            end
            DRAIN: begin
                d0_nx     = bub_d0;
                d1_nx     = bub_d1;
                mulsel_nx = bub_mul;
                add_nx    = bub_add;
                drain_nx  = drain_cnt + 2'd1;
                // Third drain edge: the last term has reached the accumulator.
                if (drain_cnt == 2'd2) begin
                    drain_nx     = 2'd0;
                    res_data_nx  = mac_out;
                    res_valid_nx = 1'b1;
                    state_nx     = DONE;
                end
            end
            DONE: begin
                if (res_valid && res_ready) begin
                    res_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end else begin
                    res_valid_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: operand/control registers; stage p1: addsel lags the issue flag by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_lat    <= OP_DOT;
            remain    <= '0;
            drain_cnt <= 2'd0;
            started   <= 1'b0;
            data_0    <= '0;
            data_1    <= '0;
            mulsel    <= 1'b0;
            add_p0    <= 1'b0;
            addsel    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_nx;
            op_lat    <= op_nx;
            remain    <= remain_nx;
            drain_cnt <= drain_nx;
            started   <= started_nx;
            data_0    <= d0_nx;
            data_1    <= d1_nx;
            mulsel    <= mulsel_nx;
            add_p0    <= add_nx;
            addsel    <= add_p0;
            res_valid <= res_valid_nx;
            res_data  <= res_data_nx;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: FIFO and MAC models around the sequencer, directed
// cases plus randomized jobs checked against an arithmetic reference.
module tb_mac_seq_ctrl;
    import mac_seq_ctrl_pkg::*;

    localparam int LEN_W = 8;
    localparam int MODV  = 1 << DATA_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  op = 1'b0;
    logic [LEN_W-1:0]      len = '0;
    logic                  res_ready = 1'b0;
    logic                  busy, a_empty, b_empty, a_rd, b_rd, mulsel, addsel, res_valid;
    logic [DATA_WIDTH-1:0] a_data, b_data, data_0, data_1, mac_out, res_data;

    logic [DATA_WIDTH-1:0] a_mem [64];
    logic [DATA_WIDTH-1:0] b_mem [64];
    int a_wp = 0, a_rp = 0, b_wp = 0, b_rp = 0;
    int cyc = 0, a_pops = 0, b_pops = 0, last_pop = 0;
    int s_cyc = 0, a0 = 0, b0 = 0;
    int n_cmp = 0, n_bad = 0;
    logic [DATA_WIDTH-1:0] mul_r = '0, acc_r = '0;

    mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .len(len), .busy(busy),
        .a_empty(a_empty), .b_empty(b_empty), .a_rd(a_rd), .b_rd(b_rd),
        .a_data(a_data), .b_data(b_data), .mulsel(mulsel), .addsel(addsel),
        .data_0(data_0), .data_1(data_1), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    assign a_empty = (a_wp == a_rp);
    assign b_empty = (b_wp == b_rp);
    assign a_data  = a_mem[a_rp % 64];
    assign b_data  = b_mem[b_rp % 64];
    assign mac_out = acc_r;

    // FIFO read side, pop bookkeeping and the two-stage MAC
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_rd) begin
            a_rp     <= a_rp + 1;
            a_pops   <= a_pops + 1;
            last_pop <= cyc + 1;
        end
        if (b_rd) begin
            b_rp   <= b_rp + 1;
            b_pops <= b_pops + 1;
        end
        mul_r <= mulsel ? DATA_WIDTH'(data_0 * mul_r) : DATA_WIDTH'(data_0 * data_1);
        acc_r <= addsel ? DATA_WIDTH'(acc_r + mul_r) : mul_r;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_a(input int v);
        a_mem[a_wp % 64] = DATA_WIDTH'(v);
        a_wp++;
    endtask

    task automatic push_b(input int v);
        b_mem[b_wp % 64] = DATA_WIDTH'(v);
        b_wp++;
    endtask

    function automatic int ref_mac(input logic o, input int n, input int av[8], input int bv[8]);
        int r;
        r = (o == OP_DOT) ? 0 : 1;
        for (int i = 0; i < n; i++)
            r = (o == OP_DOT) ? (r + av[i] * bv[i]) % MODV : (r * av[i]) % MODV;
        return r;
    endfunction

    task automatic start_job(input logic o, input int n);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        len   = LEN_W'(n);
        a0    = a_pops;
        b0    = b_pops;
        @(posedge clk);
        #1;
        s_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic o, input int n,
                                input int exp_res, input int exp_off, input int hold);
        int at;
        int held;
        wait_valid(at);
        chk({tag, "_valid"}, int'(res_valid), 1);
        chk({tag, "_data"}, int'(res_data), exp_res);
        if (exp_off >= 0) chk({tag, "_latency"}, at - s_cyc, exp_off);
        if (n > 0) chk({tag, "_lastpop_to_valid"}, at - last_pop, 3);
        chk({tag, "_busy"}, int'(busy), 1);
        held = int'(res_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, int'(res_valid), 1);
            chk({tag, "_hold_data"}, int'(res_data), held);
            chk({tag, "_hold_busy"}, int'(busy), 1);
            start = (i == 3);
            op    = OP_CHAIN;
            len   = LEN_W'(1);
        end
        chk({tag, "_a_pops"}, a_pops - a0, n);
        chk({tag, "_b_pops"}, b_pops - b0, (o == OP_DOT) ? n : 0);
        @(negedge clk);
        start     = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_valid"}, int'(res_valid), 0);
    endtask

    initial begin
        int av[8];
        int bv[8];
        int rn;
        logic ro;

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_data0", int'(data_0), 0);
        chk("rst_a_rd", int'(a_rd), 0);
        rst = 1'b0;

        push_a(1); push_a(2); push_a(3);
        push_b(4); push_b(5); push_b(6);
        start_job(OP_DOT, 3);
        check_result("dot3", OP_DOT, 3, 32, 6, 0);

        push_a(2); push_a(3); push_a(1); push_a(5);
        start_job(OP_CHAIN, 4);
        check_result("chain4", OP_CHAIN, 4, 30, 7, 0);

        push_a(3); push_a(7); push_b(2);
        start_job(OP_DOT, 2);
        fork
            check_result("dot_stall", OP_DOT, 2, 13, 7, 0);
            begin
                repeat (3) @(posedge clk);
                #1 push_b(1);
            end
        join

        push_a(2); push_a(3);
        start_job(OP_CHAIN, 4);
        fork
            check_result("chain_stall", OP_CHAIN, 4, 30, 9, 0);
            begin
                repeat (4) @(posedge clk);
                #1;
                push_a(1); push_a(5);
            end
        join

        push_a(255); push_a(16); push_b(255); push_b(16);
        start_job(OP_DOT, 2);
        check_result("overflow", OP_DOT, 2, 1, 5, 0);

        start_job(OP_DOT, 0);
        check_result("len0", OP_DOT, 0, 0, 1, 0);

        push_a(3); push_a(9); push_b(4); push_b(9);
        start_job(OP_DOT, 1);
        check_result("backpressure", OP_DOT, 1, 12, 4, 10);
        start_job(OP_DOT, 1);
        check_result("after_bp", OP_DOT, 1, 81, 4, 0);

        push_a(5); push_a(6); push_a(7);
        push_b(2); push_b(3); push_b(4);
        start_job(OP_DOT, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_a_rd", int'(a_rd), 0);
        chk("midrst_b_rd", int'(b_rd), 0);
        chk("midrst_data0", int'(data_0), 0);
        chk("midrst_data1", int'(data_1), 0);
        chk("midrst_mulsel", int'(mulsel), 0);
        chk("midrst_addsel", int'(addsel), 0);
        chk("midrst_valid", int'(res_valid), 0);
        chk("midrst_resdata", int'(res_data), 0);
        chk("midrst_pops", a_pops - a0, 1);
        @(negedge clk);
        rst = 1'b0;
        start_job(OP_DOT, 2);
        check_result("post_rst", OP_DOT, 2, 46, 5, 0);

        for (int j = 0; j < 12; j++) begin
            ro = 1'($urandom_range(0, 1));
            rn = int'($urandom_range(1, 6));
            for (int i = 0; i < 8; i++) begin
                av[i] = int'($urandom_range(0, MODV - 1));
                bv[i] = int'($urandom_range(0, MODV - 1));
            end
            start_job(ro, rn);
            fork
                check_result("rand", ro, rn, ref_mac(ro, rn, av, bv), -1,
                             int'($urandom_range(0, 5)));
                begin
                    for (int i = 0; i < rn; i++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        push_a(av[i]);
                        if (ro == OP_DOT) push_b(bv[i]);
                    end
                end
            join
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the two-stage MAC datapath (multiply register followed by an accumulate register). It pulls operand streams from two first-word-fall-through operand FIFOs and drives the MAC's mulsel, addsel, data_0 and data_1. It accounts for the MAC pipeline latency, captures the final mac_out into a result register, and presents it on a valid/ready port. It sits between the operand FIFOs and the result consumer; the MAC is instantiated beside it in the parent.

## Interface
- LEN_W, default 8: width of the job length; maximum job is 2^LEN_W-1 terms.
- Data width is the project-wide `DATA_WIDTH` define; there is no local parameter for it.
- clk, in, 1: single clock; all logic is rising-edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: job request; accepted only in IDLE.
- op, in, 1: 0 = DOT (sum of a_i*b_i); 1 = CHAIN (product of a_i). Sampled with start.
- len, in, LEN_W: number of terms; sampled with start.
- busy, out, 1: high in every state except IDLE.
- a_empty / b_empty, in, 1: FIFO empty flags.
- a_rd / b_rd, out, 1: pop strobes; combinational, one word popped per high cycle.
- a_data / b_data, in, DATA_WIDTH: FIFO head words, valid whenever the matching empty flag is low.
- mulsel, addsel, out, 1: MAC controls, both registered.
- data_0, data_1, out, DATA_WIDTH: MAC operands, registered.
- mac_out, in, DATA_WIDTH: MAC accumulator output.
- res_valid, out, 1: result available.
- res_ready, in, 1: consumer accepts the result.
- res_data, out, DATA_WIDTH: result, held stable while res_valid is high.

## Operation
- States are IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - MAC drive is data_0=0, data_1=0, mulsel=0, addsel=0, which flushes the MAC to 0.
  - start=1 latches op and len.
  - len=0 goes directly to DONE with res_data=0, and no pop occurs.
  - Any other len goes to RUN.
- **RUN, term issue:**
  - DOT: issue when a_empty=0 and b_empty=0. a_rd and b_rd are asserted together. data_0=a_data, data_1=b_data, mulsel=0.
  - CHAIN: issue when a_empty=0. Only a_rd is asserted. The first term drives data_0=a_data, data_1=1, mulsel=0. Later terms drive data_0=a_data, mulsel=1.
- **RUN, bubble** (issue condition false). No pop; the MAC drive holds its value:
  - DOT: data_0=0, data_1=0, mulsel=0, so the product is 0 and the accumulator is unchanged.
  - CHAIN: data_0=1, mulsel=1, so the multiply register is unchanged. If the bubble falls before the first term, the IDLE drive is used instead.
- **addsel** is a registered one-cycle-delayed copy of the issue-side flag:
  - DOT: the flag is 1 for every term except the first, and 1 for bubbles after the first term.
  - CHAIN: always 0.
- **RUN to DRAIN:** on the edge that pops term len. The remaining-term counter decrements per pop.
- **DRAIN:**
  - Drives the bubble pattern for 3 cycles.
  - On the 3rd edge, res_data<=mac_out and res_valid<=1, then go to DONE.
- **DONE:**
  - Drives the IDLE pattern.
  - res_valid && res_ready returns to IDLE on that edge.
  - res_valid may stay high indefinitely.
- start outside IDLE is ignored.
- Arithmetic is modulo 2^DATA_WIDTH, with truncation inherited from the MAC. The controller adds no saturation.
- Reset in any state:
  - State goes to IDLE and all outputs go to 0.
  - Words already popped are lost; FIFO contents are untouched.

## Timing
- Start is accepted at edge S; the first possible pop is in the cycle after S.
- For a term popped at edge E:
  - data_0/data_1/mulsel update at E.
  - The MAC multiply register updates at E+1.
  - The accumulator updates at E+2, using the addsel set at E+1.
- For the last pop at edge E_L:
  - res_data is captured and res_valid rises at E_L+3.
  - With no stalls, res_valid rises at S+len+3.
- Each bubble cycle in RUN adds exactly one cycle to that figure.
- Back-to-back jobs: start can be accepted at the earliest one edge after the result handshake completes.

## Structure
- The shared defines package holds `DATA_WIDTH`, the op encodings OP_DOT=0 and OP_CHAIN=1, and the 2-bit state encodings (IDLE=0, RUN=1, DRAIN=2, DONE=3).
- A single module with no sub-module. The term counter, drain counter and addsel delay register live inline.
- The MAC is instantiated in the parent, not inside this block.

## Test plan
- **DOT, len=3:** a={1,2,3}, b={4,5,6}, FIFOs pre-filled, start at S. Expect res_data=32 and res_valid high at S+6; exactly 3 a_rd and 3 b_rd pulses.
- **CHAIN, len=4:** a={2,3,1,5}, b FIFO empty throughout. Expect res_data=30 and zero b_rd pulses.
- **DOT stall:** a={3,7}, b={2}; b's 2nd word (1) is written 2 cycles late. Expect res_data=13 with res_valid 2 cycles later than the no-stall case. Repeat in CHAIN with a 2-cycle a_empty gap: product unchanged.
- **Overflow and len=0:**
  - DATA_WIDTH=8, DOT len=2, a={255,16}, b={255,16}. Expect res_data=1, since (65025+256) mod 256 = 1.
  - Then len=0. Expect res_data=0 with res_valid at S+1 and no pops.
- **Backpressure:** hold res_ready=0 for 10 cycles. Expect res_valid and res_data stable and busy=1. A start pulse during that window is ignored, and no pops occur.
- **Reset mid-RUN:** assert rst after 1 of 3 terms of a DOT job. Expect all outputs 0 immediately and state IDLE. A fresh len=2 job on the remaining FIFO words computes correctly.
